// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and sequencer for a single-ported word data memory.
// Port 0 is the CPU MEM stage. Port 1 is a secondary master, such as debug or
// DMA. Each accepted request runs IDLE -> ISSUE -> DONE:
//   - The request is sampled in IDLE.
//   - The memory strobe fires in ISSUE.
//   - The registered ack/err pulse is presented in DONE.
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins simultaneous requests
//                                        and there is no round-robin pointer.
//                           undefined : round-robin between the two ports.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   pN_req/we/addr/wdata  request from port N (held until its ack)
//   pN_ack/err            one-cycle completion pulse, error flag valid with ack
//   pN_rdata              last successful load data for port N
//   mem_addr/read/write/wdata, mem_rdata  single-ported memory interface
//   busy                  high in ISSUE and DONE
//   grant_id              port being served (holds its last value when idle)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

  // A request is illegal when it is not word aligned or its word index is
  // past the end of the attached memory.
  function automatic logic addr_illegal(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH_WORDS);
  endfunction

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic        illegal_q, illegal_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        busy_q, busy_d;
  logic        p0_ack_q, p0_ack_d;
  logic        p1_ack_q, p1_ack_d;
  logic        p0_err_q, p0_err_d;
  logic        p1_err_q, p1_err_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic        ptr_q, ptr_d;
`endif

  logic        any_req_s;
  logic        win_s;
  logic        win_we_s;
  logic [31:0] win_addr_s;
  logic [31:0] win_wdata_s;

  // Winner selection and payload mux, only consumed in IDLE.
  always_comb begin
    any_req_s = p0_req | p1_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (p0_req) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`else
    // ptr_q names the preferred port when both ask in the same cycle.
    if (p0_req && p1_req) begin
      win_s = ptr_q;
    end else if (p1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`endif
    if (win_s) begin
      win_we_s    = p1_we;
      win_addr_s  = p1_addr;
      win_wdata_s = p1_wdata;
    end else begin
      win_we_s    = p0_we;
      win_addr_s  = p0_addr;
      win_wdata_s = p0_wdata;
    end
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    illegal_d   = illegal_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          grant_d     = win_s;
          we_d        = win_we_s;
          illegal_d   = addr_illegal(win_addr_s);
          mem_addr_d  = win_addr_s;
          mem_wdata_d = win_wdata_s;
          // The strobes are registered here so that they are high in ISSUE.
          mem_read_d  = !win_we_s && !addr_illegal(win_addr_s);
          mem_write_d = win_we_s && !addr_illegal(win_addr_s);
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // Memory read data is valid during the strobe cycle; capture it on exit.
        if (!we_q && !illegal_q) begin
          if (grant_q) begin
            p1_rdata_d = mem_rdata;
          end else begin
            p0_rdata_d = mem_rdata;
          end
        end else begin
          p0_rdata_d = p0_rdata_q;
        end
        if (grant_q) begin
          p1_ack_d = 1'b1;
          p1_err_d = illegal_q;
        end else begin
          p0_ack_d = 1'b1;
          p0_err_d = illegal_q;
        end
        state_d = DONE;
      end
      DONE: begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
        ptr_d = ~grant_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      illegal_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= 32'h0000_0000;
      p1_rdata_q  <= 32'h0000_0000;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      illegal_q   <= illegal_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p0_err    = p0_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_ack    = p1_ack_q;
  assign p1_err    = p1_err_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter with DEPTH = 32.
// A behavioural memory is attached to the memory port.
// Expected ack/err/rdata records are pushed when a request is driven and
// popped by a monitor when an ack pulse appears. Cycle-exact strobe, busy
// and latency checks are made inline.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic        busy, grant_id;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp;
  int          n_bad;
  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  logic [31:0] ref_rdata [0:1];

  dmem_arbiter #(.DEPTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p0_ack   (p0_ack),
    .p0_err   (p0_err),
    .p0_rdata (p0_rdata),
    .p1_ack   (p1_ack),
    .p1_err   (p1_err),
    .p1_rdata (p1_rdata),
    .mem_addr (mem_addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: asynchronous read, write on the clock edge. It is
  // refilled with a known pattern while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (mem_write) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[6:2]];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic ref_reset();
    ref_rdata[0] = 32'h0000_0000;
    ref_rdata[1] = 32'h0000_0000;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'hA500_0000 + 32'(i);
  endtask

  // Reference view of an access; the result is queued for the ack monitor.
  task automatic expect_acc(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    exp_t e;
    logic ill;
    ill = (addr[1:0] != 2'b00) || (addr >= 32'd128);
    if (!ill && we) ref_mem[addr[6:2]] = wdata;
    if (!ill && !we) ref_rdata[port] = ref_mem[addr[6:2]];
    e.port  = port;
    e.err   = ill;
    e.rdata = ref_rdata[port];
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_reset();
  endtask

  // One isolated access. Entered and left at posedge+1 of an IDLE cycle.
  task automatic do_single(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    logic ill;
    ill = (addr[1:0] != 2'b00) || (addr >= 32'd128);
    expect_acc(port, we, addr, wdata);
    drive(port, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    check_eq("iss_read",  32'(mem_read),  32'(!we && !ill));
    check_eq("iss_write", 32'(mem_write), 32'(we && !ill));
    check_eq("iss_addr",  mem_addr, addr);
    if (we) check_eq("iss_wdata", mem_wdata, wdata);
    check_eq("iss_busy",  32'(busy), 32'd1);
    check_eq("iss_grant", 32'(grant_id), 32'(port));
    check_eq("iss_noack", 32'(p0_ack | p1_ack), 32'd0);
    @(posedge clk); #1;
    check_eq("done_ack",    32'(port ? p1_ack : p0_ack), 32'd1);
    check_eq("done_err",    32'(port ? p1_err : p0_err), 32'(ill));
    check_eq("done_strobe", 32'(mem_read | mem_write), 32'd0);
    check_eq("done_busy",   32'(busy), 32'd1);
    check_eq("done_addr",   mem_addr, addr);
    drive(port, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    @(posedge clk); #1;
    check_eq("idle_busy",   32'(busy), 32'd0);
    check_eq("idle_strobe", 32'(mem_read | mem_write), 32'd0);
    check_eq("idle_ack",    32'(p0_ack | p1_ack), 32'd0);
  endtask

  // Scoreboard monitor: each ack pulse must match the oldest queued record.
  always @(negedge clk) begin
    if (p0_ack === 1'b1 || p1_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_extra_ack", 32'(p0_ack | p1_ack), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("sb_both_ack", 32'(p0_ack & p1_ack), 32'd0);
        check_eq("sb_port",  32'(p1_ack), 32'(mon_e.port));
        check_eq("sb_err",   32'(p1_ack ? p1_err : p0_err), 32'(mon_e.err));
        check_eq("sb_rdata", p1_ack ? p1_rdata : p0_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    int n_acks;
    int cyc;
    int last;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    ref_reset();

    // Reset values.
    do_reset();
    check_eq("rst_ack",   32'(p0_ack | p1_ack), 32'd0);
    check_eq("rst_err",   32'(p0_err | p1_err), 32'd0);
    check_eq("rst_strb",  32'(mem_read | mem_write), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_p0rd",  p0_rdata, 32'h0);
    check_eq("rst_p1rd",  p1_rdata, 32'h0);
    check_eq("rst_maddr", mem_addr, 32'h0);
    check_eq("rst_mwd",   mem_wdata, 32'h0);

    // Store, load-back, port isolation, top legal word, cross-port data.
    do_single(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    do_single(1'b0, 1'b0, 32'h0000_0008, 32'h0);
    check_eq("p0_rd_store", p0_rdata, 32'hDEAD_BEEF);
    check_eq("p1_rd_clean", p1_rdata, 32'h0);
    do_single(1'b1, 1'b0, 32'h0000_007C, 32'h0);
    do_single(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
    do_single(1'b0, 1'b0, 32'h0000_0010, 32'h0);

    // Both ports saturated with loads.
    do_reset();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) expect_acc(1'b0, 1'b0, 32'h0, 32'h0);
    expect_acc(1'b1, 1'b0, 32'h4, 32'h0);
`else
    for (int k = 0; k < 3; k++) begin
      expect_acc(1'b0, 1'b0, 32'h0, 32'h0);
      expect_acc(1'b1, 1'b0, 32'h4, 32'h0);
    end
`endif
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    n_acks = 0;
    cyc = 0;
    last = 0;
    while (n_acks < 6 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_ack || p1_ack) begin
        n_acks++;
        if (n_acks == 1) check_eq("burst_latency", 32'(cyc), 32'd2);
        else             check_eq("burst_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (n_acks == 5) p0_req = 1'b0;
        if (n_acks == 6) p1_req = 1'b0;
`else
        if (n_acks == 6) begin
          p0_req = 1'b0;
          p1_req = 1'b0;
        end
`endif
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    check_eq("burst_acks", 32'(n_acks), 32'd6);
    @(posedge clk); #1;

    // Illegal accesses leave rdata alone and never strobe.
    do_single(1'b1, 1'b0, 32'h0000_0006, 32'h0);
    do_single(1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678);
    check_eq("ill_p1rd", p1_rdata, 32'hA500_0001);

    // Reset during the ISSUE cycle of a p0 load.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    @(posedge clk); #1;
    check_eq("abort_strobe", 32'(mem_read), 32'd1);
    reset  = 1'b1;
    p0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_reset();
    check_eq("abort_busy",  32'(busy), 32'd0);
    check_eq("abort_strb",  32'(mem_read | mem_write), 32'd0);
    check_eq("abort_ack",   32'(p0_ack | p1_ack), 32'd0);
    @(posedge clk); #1;
    check_eq("abort_ack2",  32'(p0_ack), 32'd0);
    check_eq("abort_p0rd",  p0_rdata, 32'h0);
    do_single(1'b0, 1'b0, 32'h0000_0004, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
